// File: rtl/fpga_config_pkg.sv
// rtl/fpga_config_pkg.sv - shared state type, CRC constants and sizing helpers for config_loader
package fpga_config_pkg;

    localparam int          CELL_CONFIG_BITS = 19;
    localparam int          CRC_WIDTH        = 16;
    localparam logic [15:0] CRC_POLY         = 16'h1021;
    localparam logic [15:0] CRC_INIT         = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_CHECK  = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } config_loader_state_t;

    function automatic int total_bits(input int cell_count);
        return cell_count * CELL_CONFIG_BITS;
    endfunction

    function automatic int word_count(input int cell_count, input int data_width);
        return (total_bits(cell_count) + data_width - 1) / data_width;
    endfunction

    function automatic int trailer_words(input int data_width);
        return (CRC_WIDTH + data_width - 1) / data_width;
    endfunction

endpackage

// File: rtl/crc16_serial.sv
// rtl/crc16_serial.sv - bit-serial CRC-16-CCITT, MSB-first feedback; used only when CONFIG_LOADER_CRC_EN is defined
module crc16_serial
    import fpga_config_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic feedback;

    assign feedback = crc[15] ^ bit_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (enable) begin
            crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/config_loader.sv
// rtl/config_loader.sv - serializes a word stream into the cell config chain; CONFIG_LOADER_CRC_EN adds a CRC-16 trailer check
module config_loader
    import fpga_config_pkg::*;
#(
    parameter int CELL_COUNT = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_n,
    input  logic                  i_Start,
    input  logic [DATA_WIDTH-1:0] i_Data,
    input  logic                  i_DataValid,
    output logic                  o_DataReady,
    output logic                  o_ConfigClock,
    output logic                  o_ConfigData,
    output logic                  o_ConfigActive,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Error
);

    localparam int TOTAL_BITS = total_bits(CELL_COUNT);
    localparam int BIT_W      = $clog2(TOTAL_BITS);
    localparam int WB_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TOTAL_BITS - 1);
    localparam logic [WB_W-1:0]  LAST_WB  = WB_W'(DATA_WIDTH - 1);

`ifdef CONFIG_LOADER_CRC_EN
    localparam config_loader_state_t AFTER_SHIFT = ST_CHECK;
    localparam int TRAILER_WORDS = trailer_words(DATA_WIDTH);
    localparam int TIDX_W        = (TRAILER_WORDS > 1) ? $clog2(TRAILER_WORDS) : 1;
    localparam logic [TIDX_W-1:0] LAST_TIDX = TIDX_W'(TRAILER_WORDS - 1);

    logic [15:0]                         crc;
    logic [TRAILER_WORDS*DATA_WIDTH-1:0] trailer;
    logic [TRAILER_WORDS*DATA_WIDTH-1:0] trailer_n;
    logic [TIDX_W-1:0]                   trailer_idx;
    logic                                take_trailer;
    logic                                finish_err;
    logic                                crc_match;
    logic                                error;
`else
    localparam config_loader_state_t AFTER_SHIFT = ST_SETTLE;
`endif

    config_loader_state_t state, state_n;

    logic [DATA_WIDTH-1:0] shreg;
    logic [BIT_W-1:0]      bit_cnt;
    logic [WB_W-1:0]       word_bit;
    logic                  phase;
    logic                  settle_cnt;
    logic                  busy;
    logic                  done;
    logic                  active;
    logic                  start_load;
    logic                  load_word;
    logic                  step_bit;
    logic                  finish_ok;
    logic                  data_ready;
    logic                  last_bit;
    logic                  word_end;

    assign last_bit = (bit_cnt == LAST_BIT);
    assign word_end = (word_bit == LAST_WB);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        start_load = 1'b0;
        load_word  = 1'b0;
        step_bit   = 1'b0;
        finish_ok  = 1'b0;
        data_ready = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
        take_trailer = 1'b0;
        finish_err   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (i_Start) begin
                    start_load = 1'b1;
                    state_n    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                data_ready = 1'b1;
                if (i_DataValid) begin
                    load_word = 1'b1;
                    state_n   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // a bit retires at the end of its clock-high phase
                if (phase) begin
                    step_bit = 1'b1;
                    if (last_bit) begin
                        state_n = AFTER_SHIFT;
                    end else if (word_end) begin
                        state_n = ST_FETCH;
                    end
                end
            end
`ifdef CONFIG_LOADER_CRC_EN
            ST_CHECK: begin
                data_ready = 1'b1;
                if (i_DataValid) begin
                    take_trailer = 1'b1;
                    if (trailer_idx == LAST_TIDX) begin
                        if (crc_match) begin
                            state_n = ST_SETTLE;
                        end else begin
                            finish_err = 1'b1;
                            state_n    = ST_IDLE;
                        end
                    end
                end
            end
`endif
            ST_SETTLE: begin
                if (settle_cnt) begin
                    finish_ok = 1'b1;
                    state_n   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            word_bit   <= '0;
            phase      <= 1'b0;
            settle_cnt <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            active     <= 1'b0;
        end else begin
            // second SETTLE cycle is the one where this flag is already set
            settle_cnt <= (state == ST_SETTLE);
            if (start_load) begin
                busy    <= 1'b1;
                done    <= 1'b0;
                active  <= 1'b0;
                bit_cnt <= '0;
            end
            if (load_word) begin
                shreg    <= i_Data;
                word_bit <= '0;
                phase    <= 1'b0;
            end
            if (state == ST_SHIFT) begin
                phase <= ~phase;
            end
            if (step_bit) begin
                shreg    <= shreg >> 1;
                bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
                word_bit <= word_end ? '0 : word_bit + 1'b1;
            end
            if (finish_ok) begin
                busy   <= 1'b0;
                done   <= 1'b1;
                active <= 1'b1;
            end
`ifdef CONFIG_LOADER_CRC_EN
            if (finish_err) begin
                busy <= 1'b0;
            end
`endif
        end
    end

`ifdef CONFIG_LOADER_CRC_EN
    crc16_serial u_crc (
        .clk    (i_Clock),
        .rst_n  (i_Reset_n),
        .clear  (start_load),
        .enable (step_bit),
        .bit_in (shreg[0]),
        .crc    (crc)
    );

    // trailer words arrive least-significant word first
    always_comb begin
        trailer_n = trailer;
        trailer_n[trailer_idx*DATA_WIDTH +: DATA_WIDTH] = i_Data;
    end

    assign crc_match = (trailer_n[15:0] == crc);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            trailer     <= '0;
            trailer_idx <= '0;
            error       <= 1'b0;
        end else begin
            if (start_load) begin
                trailer_idx <= '0;
                error       <= 1'b0;
            end
            if (take_trailer) begin
                trailer     <= trailer_n;
                trailer_idx <= trailer_idx + 1'b1;
            end
            if (finish_err) begin
                error <= 1'b1;
            end
        end
    end

    assign o_Error = error;
`else
    assign o_Error = 1'b0;
`endif

    // phase is only ever high inside SHIFT, so it doubles as a glitch-free config clock
    assign o_DataReady    = data_ready;
    assign o_ConfigClock  = phase;
    assign o_ConfigData   = shreg[0];
    assign o_ConfigActive = active;
    assign o_Busy         = busy;
    assign o_Done         = done;

endmodule
